// File: rtl/yutorina_bus_if_if.sv
// Bus-side signal bundle between one CPU master port and the arbiter / address decoder / slaves.
interface yutorina_bus_if_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  // Handshake: the master holds bus_req_ low from request until completion. After it sees
  // bus_grnt_ low it drives bus_as_ low for exactly one cycle together with a stable
  // bus_addr/bus_rw/bus_wr_data. The slave completes by pulling bus_rdy_ low for one cycle,
  // with bus_rd_data valid in that same cycle. All strobes are active-low.
  logic              bus_req_;
  logic              bus_grnt_;
  logic              bus_as_;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;

  modport master (
    output bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
    input  bus_grnt_, bus_rd_data, bus_rdy_
  );

  modport slave (
    input  bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
    output bus_grnt_, bus_rd_data, bus_rdy_
  );
endinterface

// File: rtl/yutorina_bus_if.sv
// CPU-side bus interface unit: turns a pipeline memory request into an arbitrated, handshaked
// bus transaction, stalls the pipeline until the slave answers and holds read data while frozen.
module yutorina_bus_if #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16   // must be >= 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              cpu_as_,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              busy,
  output logic              err,
  output logic [1:0]        dbg_state,
  yutorina_bus_if_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    STALL  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              as_q, as_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    as_d        = 1'b1;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wd_d        = wd_q;
    rd_buf_d    = rd_buf_q;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    busy        = 1'b0;
    cpu_rd_data = rd_buf_q;

    case (state_q)
      IDLE: begin
        if (!cpu_as_ && !flush) begin
          busy    = 1'b1;
          req_d   = 1'b0;
          state_d = REQ;
        end
      end

      REQ: begin
        busy = 1'b1;
        if (flush) begin
          req_d   = 1'b1;
          state_d = IDLE;
        end else if (!bus.bus_grnt_) begin
          as_d    = 1'b0;
          rw_d    = cpu_rw;
          addr_d  = cpu_addr;
          wd_d    = cpu_wr_data;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        // flush is deliberately not looked at: once the strobe is out the access must finish
        if (!bus.bus_rdy_) begin
          cpu_rd_data = bus.bus_rd_data;
          rd_buf_d    = bus.bus_rd_data;
          req_d       = 1'b1;
          state_d     = stall ? STALL : IDLE;
        end else begin
          busy = 1'b1;
          if (cnt_q == CNT_LAST) begin
            err_d    = 1'b1;
            rd_buf_d = '0;
            req_d    = 1'b1;
            state_d  = stall ? STALL : IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      STALL: begin
        if (!stall) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      req_q    <= 1'b1;
      as_q     <= 1'b1;
      rw_q     <= 1'b1;
      addr_q   <= '0;
      wd_q     <= '0;
      rd_buf_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      as_q     <= as_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      rd_buf_q <= rd_buf_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.bus_req_    = req_q;
  assign bus.bus_as_     = as_q;
  assign bus.bus_rw      = rw_q;
  assign bus.bus_addr    = addr_q;
  assign bus.bus_wr_data = wd_q;
  assign err             = err_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_yutorina_bus_if.sv
// Bench for yutorina_bus_if: behavioural arbiter/slave, cycle-indexed transaction driver and
// arithmetic timing model derived from grant delay, slave latency and the timeout window.
module tb_yutorina_bus_if;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          cpu_as_ = 1'b1;
  logic          cpu_rw = 1'b1;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wr_data = '0;
  logic [DW-1:0] cpu_rd_data;
  logic          busy;
  logic          err;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;

  yutorina_bus_if_if #(.ADDR_W(AW), .DATA_W(DW)) bus_i ();

  yutorina_bus_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .cpu_as_     (cpu_as_),
    .cpu_rw      (cpu_rw),
    .cpu_addr    (cpu_addr),
    .cpu_wr_data (cpu_wr_data),
    .cpu_rd_data (cpu_rd_data),
    .busy        (busy),
    .err         (err),
    .dbg_state   (dbg_state),
    .bus         (bus_i.master)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- arbiter + slave model ----------------
  int            grant_delay = 0;   // cycles bus_req_ is seen low before grant
  int            slave_lat   = 1;   // cycles from bus_as_ to bus_rdy_ (0 = never answers)
  logic [DW-1:0] slave_data  = '0;
  int            waited  = 0;
  int            pending = 0;

  always @(posedge clk) begin
    #1;
    bus_i.bus_rdy_    = 1'b1;
    bus_i.bus_rd_data = $urandom;
    if (!rst) begin
      waited = 0;
      pending = 0;
      bus_i.bus_grnt_ = 1'b1;
    end else begin
      if (!bus_i.bus_req_) begin
        bus_i.bus_grnt_ = (waited >= grant_delay) ? 1'b0 : 1'b1;
        waited++;
      end else begin
        bus_i.bus_grnt_ = 1'b1;
        waited = 0;
      end
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          bus_i.bus_rdy_    = 1'b0;
          bus_i.bus_rd_data = slave_data;
        end
      end
      if (!bus_i.bus_as_ && slave_lat > 0) pending = slave_lat;
    end
  end

  // ---------------- expectation model ----------------
  logic [DW-1:0] exp_q[$];

  function automatic bit answered(input int lat);
    return (lat >= 1) && (lat <= T - 1);
  endfunction

  // cycle (counted from the request cycle) in which busy first drops
  function automatic int exp_done(input int g, input int lat);
    int as_c;
    as_c = 2 + g;
    return answered(lat) ? as_c + lat : as_c + T;
  endfunction

  // ---------------- transaction driver ----------------
  int            o_done, o_as_first, o_as_cnt, o_req_low, o_err_cycle, o_err_cnt, o_hold_bad;
  logic [DW-1:0] o_rd, o_wd;
  logic [AW-1:0] o_addr;
  logic          o_rw;

  // Called just after a rising edge; returns just after a rising edge. Cycle 0 is the request.
  task automatic run_txn(input int g, input int lat, input int stall_n, input logic rw,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [DW-1:0] rd);
    grant_delay = g;
    slave_lat   = lat;
    slave_data  = rd;
    o_done = -1; o_as_first = -1; o_as_cnt = 0; o_req_low = 0;
    o_err_cycle = -1; o_err_cnt = 0; o_hold_bad = 0;
    o_rd = '0; o_wd = '0; o_addr = '0; o_rw = 1'b1;
    for (int c = 0; c < 80; c++) begin
      cpu_as_     = !(c == 0 || (o_done >= 0 && c > o_done && c <= o_done + stall_n));
      cpu_rw      = (c <= 1 + g) ? rw : ~rw;
      cpu_addr    = (c <= 1 + g) ? addr : ~addr;
      cpu_wr_data = (c <= 1 + g) ? wd : ~wd;
      stall       = (stall_n > 0) && (o_done < 0 || c < o_done + stall_n);
      @(negedge clk);
      if (!bus_i.bus_as_) begin
        o_as_cnt++;
        if (o_as_first < 0) begin
          o_as_first = c;
          o_addr     = bus_i.bus_addr;
          o_rw       = bus_i.bus_rw;
          o_wd       = bus_i.bus_wr_data;
        end
      end
      if (!bus_i.bus_req_) o_req_low++;
      if (err) begin
        o_err_cnt++;
        if (o_err_cycle < 0) o_err_cycle = c;
      end
      if (o_done >= 0 && c > o_done && cpu_rd_data !== o_rd) o_hold_bad++;
      if (o_done < 0 && c > 0 && !busy) begin
        o_done = c;
        o_rd   = cpu_rd_data;
      end
      @(posedge clk);
      #1;
      if (o_done >= 0 && c >= o_done + stall_n) break;
    end
    cpu_as_ = 1'b1;
    stall   = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #3;  // reset fell at t=2, no clock edge yet
    checks++;
    if ({bus_i.bus_req_, bus_i.bus_as_, bus_i.bus_rw, err, busy} !== 5'b11100) begin
      errors++;
      $display("FAIL reset_strobes: got req/as/rw/err/busy=%b exp 11100",
               {bus_i.bus_req_, bus_i.bus_as_, bus_i.bus_rw, err, busy});
    end
    checks++;
    if (bus_i.bus_addr !== '0 || bus_i.bus_wr_data !== '0) begin
      errors++;
      $display("FAIL reset_bus_data: got addr=%0h wd=%0h exp 0 0", bus_i.bus_addr, bus_i.bus_wr_data);
    end
    checks++;
    if (cpu_rd_data !== '0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_rd_state: got rd=%0h state=%0d exp 0 0", cpu_rd_data, dbg_state);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rom_read;
    run_txn(0, 1, 0, 1'b1, 30'h10, 32'h0, 32'hDEADBEEF);
    checks++;
    if (o_done !== 3) begin errors++; $display("FAIL rom_busy_len: got %0d exp 3", o_done); end
    checks++;
    if (o_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rom_data: got %0h exp deadbeef", o_rd); end
    checks++;
    if (o_as_cnt !== 1 || o_as_first !== 2) begin
      errors++; $display("FAIL rom_as: got cnt=%0d at %0d exp 1 at 2", o_as_cnt, o_as_first);
    end
    checks++;
    if (o_addr !== 30'h10 || o_rw !== 1'b1) begin
      errors++; $display("FAIL rom_addr: got %0h rw=%b exp 10 rw=1", o_addr, o_rw);
    end
    checks++;
    if (o_req_low !== 3 || o_err_cnt !== 0) begin
      errors++; $display("FAIL rom_req: got req_low=%0d err=%0d exp 3 0", o_req_low, o_err_cnt);
    end
  endtask

  task automatic test_delayed_grant;
    run_txn(5, 1, 0, 1'b1, 30'h2a, 32'h0, 32'hCAFE0001);
    checks++;
    if (o_done + 1 !== 9) begin errors++; $display("FAIL grant_latency: got %0d exp 9", o_done + 1); end
    checks++;
    if (o_as_first !== 7 || o_as_cnt !== 1) begin
      errors++; $display("FAIL grant_as: got at %0d cnt=%0d exp at 7 cnt=1", o_as_first, o_as_cnt);
    end
    checks++;
    if (o_req_low !== 8) begin errors++; $display("FAIL grant_req_low: got %0d exp 8", o_req_low); end
    checks++;
    if (o_rd !== 32'hCAFE0001) begin errors++; $display("FAIL grant_data: got %0h exp cafe0001", o_rd); end
  endtask

  task automatic test_write;
    run_txn(1, 2, 0, 1'b0, 30'h3ff_0001, 32'hA5A5_5A5A, 32'h0BAD_F00D);
    checks++;
    if (o_rw !== 1'b0 || o_wd !== 32'hA5A5_5A5A || o_addr !== 30'h3ff_0001) begin
      errors++; $display("FAIL write_bus: got rw=%b wd=%0h addr=%0h exp 0 a5a55a5a 3ff0001", o_rw, o_wd, o_addr);
    end
    checks++;
    if (o_done !== exp_done(1, 2)) begin
      errors++; $display("FAIL write_done: got %0d exp %0d", o_done, exp_done(1, 2));
    end
  endtask

  task automatic test_flush;
    int as_seen;
    grant_delay = 100;
    slave_lat   = 1;
    cpu_as_ = 1'b0; flush = 1'b1;          // request blocked by flush in IDLE
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy: got %b exp 0", busy); end
    @(posedge clk); #1;
    flush = 1'b0;                           // now accepted
    @(negedge clk);
    checks++;
    if (bus_i.bus_req_ !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL flush_idle_req: got req=%b busy=%b exp 1 1", bus_i.bus_req_, busy);
    end
    @(posedge clk); #1;
    cpu_as_ = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_i.bus_req_ !== 1'b0) begin errors++; $display("FAIL flush_req_low: got %b exp 0", bus_i.bus_req_); end
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b0;
    as_seen = 0;
    @(negedge clk);
    checks++;
    if (bus_i.bus_req_ !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_release: got req=%b busy=%b exp 1 0", bus_i.bus_req_, busy);
    end
    for (int i = 0; i < 4; i++) begin
      if (!bus_i.bus_as_ || !bus_i.bus_req_) as_seen++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    checks++;
    if (as_seen !== 0) begin errors++; $display("FAIL flush_no_as: got %0d strobe cycles exp 0", as_seen); end
    @(posedge clk); #1;
    grant_delay = 0;
  endtask

  task automatic test_stall_hold;
    run_txn(0, 1, 4, 1'b1, 30'h44, 32'h0, 32'h12345678);
    checks++;
    if (o_rd !== 32'h12345678 || o_hold_bad !== 0) begin
      errors++; $display("FAIL stall_hold: got %0h bad_cycles=%0d exp 12345678 0", o_rd, o_hold_bad);
    end
    checks++;
    if (o_as_cnt !== 1 || o_req_low !== 3) begin
      errors++; $display("FAIL stall_no_new: got as=%0d req_low=%0d exp 1 3", o_as_cnt, o_req_low);
    end
    run_txn(0, 1, 0, 1'b1, 30'h45, 32'h0, 32'h87654321);
    checks++;
    if (o_done !== 3 || o_rd !== 32'h87654321) begin
      errors++; $display("FAIL stall_next: got done=%0d rd=%0h exp 3 87654321", o_done, o_rd);
    end
  endtask

  task automatic test_timeout;
    run_txn(0, 0, 0, 1'b1, 30'h99, 32'h0, 32'hFFFF_FFFF);
    checks++;
    if (o_err_cnt !== 1 || o_err_cycle !== 2 + T) begin
      errors++; $display("FAIL timeout_err: got cnt=%0d at %0d exp 1 at %0d", o_err_cnt, o_err_cycle, 2 + T);
    end
    checks++;
    if (o_rd !== '0 || o_done !== 2 + T) begin
      errors++; $display("FAIL timeout_rd: got rd=%0h done=%0d exp 0 %0d", o_rd, o_done, 2 + T);
    end
    checks++;
    if (o_req_low !== 1 + T || o_as_cnt !== 1) begin
      errors++; $display("FAIL timeout_req: got req_low=%0d as=%0d exp %0d 1", o_req_low, o_as_cnt, 1 + T);
    end
    run_txn(0, 1, 0, 1'b1, 30'h9a, 32'h0, 32'h0000_1234);
    checks++;
    if (o_done !== 3 || o_err_cnt !== 0 || o_rd !== 32'h1234) begin
      errors++; $display("FAIL timeout_recover: got done=%0d err=%0d rd=%0h exp 3 0 1234", o_done, o_err_cnt, o_rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] d, e;
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      exp_q.push_back(d);
      run_txn(0, 1, 0, 1'b1, AW'(i + 100), 32'h0, d);
      e = exp_q.pop_front();
      checks++;
      if (o_done !== 3 || o_rd !== e) begin
        errors++; $display("FAIL b2b_%0d: got done=%0d rd=%0h exp 3 %0h", i, o_done, o_rd, e);
      end
    end
  endtask

  task automatic test_random;
    int g, lat, sn, sel, ed;
    logic rw;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd, e;
    for (int i = 0; i < 20; i++) begin
      g   = $urandom_range(0, 3);
      sel = $urandom_range(0, 9);
      lat = (sel <= 6) ? $urandom_range(1, 4) : (sel == 7) ? T - 1 : (sel == 8) ? T : 0;
      sn  = $urandom_range(0, 2);
      rw  = 1'($urandom_range(0, 1));
      a   = AW'($urandom);
      wd  = $urandom;
      rd  = $urandom;
      ed  = exp_done(g, lat);
      exp_q.push_back(answered(lat) ? rd : '0);
      run_txn(g, lat, sn, rw, a, wd, rd);
      e = exp_q.pop_front();
      checks++;
      if (o_done !== ed || o_rd !== e) begin
        errors++; $display("FAIL rand_%0d_result: got done=%0d rd=%0h exp %0d %0h", i, o_done, o_rd, ed, e);
      end
      checks++;
      if (o_as_first !== 2 + g || o_as_cnt !== 1) begin
        errors++; $display("FAIL rand_%0d_as: got at %0d cnt=%0d exp at %0d cnt=1", i, o_as_first, o_as_cnt, 2 + g);
      end
      checks++;
      if (o_addr !== a || o_rw !== rw || o_wd !== wd) begin
        errors++; $display("FAIL rand_%0d_bus: got %0h/%b/%0h exp %0h/%b/%0h", i, o_addr, o_rw, o_wd, a, rw, wd);
      end
      checks++;
      if (o_err_cnt !== (answered(lat) ? 0 : 1) || o_hold_bad !== 0) begin
        errors++; $display("FAIL rand_%0d_err: got err=%0d hold_bad=%0d lat=%0d", i, o_err_cnt, o_hold_bad, lat);
      end
      checks++;
      if (o_req_low !== (answered(lat) ? ed : ed - 1)) begin
        errors++; $display("FAIL rand_%0d_req: got %0d exp %0d", i, o_req_low, answered(lat) ? ed : ed - 1);
      end
    end
  endtask

  task automatic test_reset_mid_access;
    int err_seen;
    grant_delay = 0;
    slave_lat   = 0;
    cpu_rw = 1'b0; cpu_addr = 30'h123_4567; cpu_wr_data = 32'h5555_AAAA; cpu_as_ = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    cpu_as_ = 1'b1;
    repeat (3) begin @(negedge clk); @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus_i.bus_req_, bus_i.bus_as_, bus_i.bus_rw, err, busy} !== 5'b11100 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL mid_reset_strobes: got %b state=%0d exp 11100 0",
                         {bus_i.bus_req_, bus_i.bus_as_, bus_i.bus_rw, err, busy}, dbg_state);
    end
    checks++;
    if (bus_i.bus_addr !== '0 || bus_i.bus_wr_data !== '0 || cpu_rd_data !== '0) begin
      errors++; $display("FAIL mid_reset_data: got %0h %0h %0h exp 0 0 0", bus_i.bus_addr, bus_i.bus_wr_data, cpu_rd_data);
    end
    err_seen = 0;
    repeat (3) begin @(negedge clk); if (err) err_seen++; end
    rst = 1'b1;
    @(posedge clk); #1;
    run_txn(0, 1, 0, 1'b1, 30'h77, 32'h0, 32'hFEED_BEEF);
    checks++;
    if (o_done !== 3 || o_rd !== 32'hFEED_BEEF || err_seen + o_err_cnt !== 0) begin
      errors++; $display("FAIL mid_reset_after: got done=%0d rd=%0h errs=%0d exp 3 feedbeef 0",
                         o_done, o_rd, err_seen + o_err_cnt);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    #2 rst = 1'b0;
    test_reset();
    test_rom_read();
    test_delayed_grant();
    test_write();
    test_flush();
    test_stall_hold();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
